// File: rtl/serial_transmitter_pkg.sv
// Shared definitions for the SCL/SDA serial link (transmitter and receiver).
package serial_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_BIT_LOW  = 3'd2,
        ST_BIT_HIGH = 3'd3,
        ST_ACK      = 3'd4,
        ST_STOP     = 3'd5,
        ST_GAP      = 3'd6
    } link_state_t;

    localparam int FRAME_BITS = 8;
    localparam int ACK_LEN    = 1;
    localparam int STOP_LEN   = 1;

    localparam int PR_LSB    = 0;
    localparam int RATE_LSB  = 4;
    localparam int SPARE_BIT = 7;

    // Assemble the on-wire byte {spare=0, rate, pr}.
    function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [3:0] pr,
                                                         input logic [2:0] rate);
        logic [FRAME_BITS-1:0] b;
        b                = '0;
        b[PR_LSB +: 4]   = pr;
        b[RATE_LSB +: 3] = rate;
        b[SPARE_BIT]     = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/serial_transmitter_if.sv
// Handshake and line signals of the serial transmitter.
interface serial_transmitter_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] pr;
    logic [2:0] rate;
    logic       scl;
    logic       sda_out;
    logic       sda_oe;
    logic       busy;
    logic       done;

    // Requester side: offers a payload, watches the line.
    modport master (
        output tx_valid, pr, rate,
        input  tx_ready, scl, sda_out, sda_oe, busy, done
    );

    // Transmitter side.
    modport slave (
        input  tx_valid, pr, rate,
        output tx_ready, scl, sda_out, sda_oe, busy, done
    );
endinterface

// File: rtl/serial_transmitter_bit_timer.sv
// Loadable down-counter with a zero flag; times the per-state durations.
module serial_bit_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load on request, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/serial_transmitter.sv
// Serial byte transmitter: packs {0, rate, pr} and shifts it LSB-first on SCL/SDA
// with start, ack slot, stop and an idle gap before the next frame.
module serial_transmitter #(
    parameter int LOW_CYCLES = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_transmitter_if.slave  bus
);
    import serial_link_pkg::*;

    localparam int MAX_LEN = (LOW_CYCLES > GAP_CYCLES) ? LOW_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_LEN) + 1;

    // Timer holds N-1 on entry so a state lasts N cycles, ending on the zero flag.
    localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LOAD  = CW'(ACK_LEN - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_LEN - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(FRAME_BITS - 1);

    link_state_t            r_state;
    link_state_t            w_state_next;
    logic [FRAME_BITS-1:0]  r_shreg;
    logic [2:0]             r_bit_cnt;
    logic                   w_zero;
    logic                   w_load;
    logic [CW-1:0]          w_load_val;
    logic                   w_scl, w_sda_out, w_sda_oe, w_ready, w_busy, w_done;
    logic                   w_handshake;

    assign w_handshake = (r_state == ST_IDLE) && bus.tx_valid;

    serial_bit_timer #(.WIDTH(CW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Payload shifter and bit counter: latch at handshake, advance after each high cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_handshake) begin
            r_shreg   <= pack_frame(bus.pr, bus.rate);
            r_bit_cnt <= '0;
        end else if (r_state == ST_BIT_HIGH) begin
            r_shreg <= r_shreg >> 1;
            if (r_bit_cnt != LAST_BIT) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Next state, timer reload on every state entry, and outputs decoded from state.
    always_comb begin
        w_state_next = r_state;
        w_load_val   = '0;
        w_scl        = 1'b0;
        w_sda_out    = 1'b1;
        w_sda_oe     = 1'b1;
        w_ready      = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
                if (bus.tx_valid) w_state_next = ST_START;
            end
            ST_START: begin
                w_sda_out = 1'b0;
                if (w_zero) w_state_next = ST_BIT_LOW;
            end
            ST_BIT_LOW: begin
                w_sda_out = r_shreg[0];
                if (w_zero) w_state_next = ST_BIT_HIGH;
            end
            ST_BIT_HIGH: begin
                // A single high cycle per bit; the receiver samples every high cycle.
                w_scl        = 1'b1;
                w_sda_out    = r_shreg[0];
                w_state_next = (r_bit_cnt == LAST_BIT) ? ST_ACK : ST_BIT_LOW;
            end
            ST_ACK: begin
                w_sda_oe = 1'b0;
                if (w_zero) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                w_done = 1'b1;
                if (w_zero) w_state_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_zero) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        case (w_state_next)
            ST_START, ST_BIT_LOW: w_load_val = LOW_LOAD;
            ST_GAP:               w_load_val = GAP_LOAD;
            ST_ACK:               w_load_val = ACK_LOAD;
            ST_STOP:              w_load_val = STOP_LOAD;
            default:              w_load_val = '0;
        endcase
    end

    assign w_load = (w_state_next != r_state);

    assign bus.scl      = w_scl;
    assign bus.sda_out  = w_sda_out;
    assign bus.sda_oe   = w_sda_oe;
    assign bus.tx_ready = w_ready;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;

endmodule

// File: tb/tb_serial_transmitter.sv
// Self-checking bench for serial_transmitter: default timing instance plus a
// LOW_CYCLES=1 / GAP_CYCLES=2 instance, checked against a per-cycle frame model.
module tb_serial_transmitter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_transmitter_if ifa ();
    serial_transmitter_if ifb ();

    serial_transmitter #(.LOW_CYCLES(2), .GAP_CYCLES(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    serial_transmitter #(.LOW_CYCLES(1), .GAP_CYCLES(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int checks = 0;
    int errors = 0;
    int frames = 0;

    typedef struct packed {
        logic ready;
        logic busy;
        logic scl;
        logic sda;
        logic oe;
        logic done;
    } obs_t;

    // Expected line state t cycles after a handshake cycle (t=0), from the frame timing rules.
    function automatic obs_t model(int t, logic [7:0] b, int L, int G);
        obs_t e;
        int   u;
        int   w;
        e = '{ready: 1'b1, busy: 1'b0, scl: 1'b0, sda: 1'b1, oe: 1'b1, done: 1'b0};
        if (t <= 0) return e;
        u = t - L - 1;
        w = u - 8 * (L + 1);
        if (w > G + 1) return e;
        e.ready = 1'b0;
        e.busy  = 1'b1;
        if (t <= L) begin
            e.sda = 1'b0;
        end else if (w < 0) begin
            e.sda = b[u / (L + 1)];
            e.scl = ((u % (L + 1)) == L);
        end else if (w == 0) begin
            e.oe = 1'b0;
        end else if (w == 1) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic obs_t sample(bit sel);
        obs_t o;
        if (sel) o = '{ready: ifb.tx_ready, busy: ifb.busy, scl: ifb.scl,
                       sda: ifb.sda_out, oe: ifb.sda_oe, done: ifb.done};
        else     o = '{ready: ifa.tx_ready, busy: ifa.busy, scl: ifa.scl,
                       sda: ifa.sda_out, oe: ifa.sda_oe, done: ifa.done};
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit sel, logic v, logic [3:0] pr, logic [2:0] rate);
        if (sel) begin
            ifb.tx_valid = v; ifb.pr = pr; ifb.rate = rate;
        end else begin
            ifa.tx_valid = v; ifa.pr = pr; ifa.rate = rate;
        end
    endtask

    // Compare all outputs; SDA value is don't-care while the line is released.
    task automatic check_obs(string tag, bit sel, obs_t exp);
        obs_t o;
        o = sample(sel);
        if (!exp.oe) o.sda = exp.sda;
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s rdy/busy/scl/sda/oe/done got=%b want=%b", tag, o, exp);
        end
    endtask

    // Starts in an IDLE cycle (handshake cycle t=0); returns at the next t=0,
    // or at cycle stop_at when stop_at>0.
    task automatic run_frame(bit sel, int L, int G, logic [3:0] pr, logic [2:0] rate,
                             bit hold_valid, bit churn, int stop_at);
        logic [7:0] b;
        int         period;
        obs_t       raw;
        logic       prev_scl;
        logic       prev_sda;
        b      = {1'b0, rate, pr};
        period = L + 8 * (L + 1) + 2 + G + 1;
        drive(sel, 1'b1, pr, rate);
        check_obs($sformatf("u%0d_f%0d_t0", sel, frames), sel, model(0, b, L, G));
        raw      = sample(sel);
        prev_scl = raw.scl;
        prev_sda = raw.sda;
        for (int t = 1; t < period && (stop_at == 0 || t <= stop_at); t++) begin
            tick();
            if (!hold_valid || churn)
                drive(sel, hold_valid, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            check_obs($sformatf("u%0d_f%0d_t%0d", sel, frames, t), sel, model(t, b, L, G));
            raw = sample(sel);
            checks++;
            assert (!(prev_scl && raw.scl)) else begin
                errors++;
                $error("FAIL scl_double_high u%0d t%0d got=%b want=0", sel, t, raw.scl);
            end
            checks++;
            assert (!raw.scl || raw.sda === prev_sda) else begin
                errors++;
                $error("FAIL sda_toggle_in_high u%0d t%0d got=%b want=%b", sel, t, raw.sda, prev_sda);
            end
            prev_scl = raw.scl;
            prev_sda = raw.sda;
        end
        if (stop_at == 0) tick();
        $display("frame %0d unit=%0d pr=%h rate=%0d byte=%h%s", frames, sel, pr, rate, b,
                 (stop_at != 0) ? " (cut by reset)" : "");
        frames++;
    endtask

    initial begin
        drive(1'b0, 1'b0, 4'h0, 3'd0);
        drive(1'b1, 1'b0, 4'h0, 3'd0);
        reset = 1'b1;
        repeat (3) tick();
        check_obs("reset_a", 1'b0, model(0, 8'h00, 2, 4));
        check_obs("reset_b", 1'b1, model(0, 8'h00, 1, 2));
        reset = 1'b0;
        tick();

        // Directed: pr=A, rate=5 -> byte 0x5A on the default timing.
        run_frame(1'b0, 2, 4, 4'hA, 3'd5, 1'b0, 1'b0, 0);
        check_obs("idle_after_5a", 1'b0, model(0, 8'h00, 2, 4));

        // Back-to-back with tx_valid held and payload churning between handshakes.
        run_frame(1'b0, 2, 4, 4'h3, 3'd6, 1'b1, 1'b1, 0);
        run_frame(1'b0, 2, 4, 4'hF, 3'd0, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b0, 4'h0, 3'd0);
        tick();

        // Reset mid-frame at cycle 12; cycle 13 must be idle, then a clean frame.
        run_frame(1'b0, 2, 4, 4'h6, 3'd2, 1'b0, 1'b0, 12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_obs("reset_mid_c13", 1'b0, model(0, 8'h00, 2, 4));
        run_frame(1'b0, 2, 4, 4'h9, 3'd3, 1'b0, 1'b0, 0);

        // Short timing instance: LOW_CYCLES=1, GAP_CYCLES=2, period 22.
        run_frame(1'b1, 1, 2, 4'hC, 3'd1, 1'b1, 1'b1, 0);
        for (int i = 0; i < 3; i++)
            run_frame(1'b1, 1, 2, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b1, 1'b1, 0);
        drive(1'b1, 1'b0, 4'h0, 3'd0);

        // 100 random back-to-back frames on the default instance.
        for (int i = 0; i < 100; i++)
            run_frame(1'b0, 2, 4, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b1, 1'b1, 0);
        drive(1'b0, 1'b0, 4'h0, 3'd0);
        repeat (3) tick();
        check_obs("final_idle_a", 1'b0, model(0, 8'h00, 2, 4));
        check_obs("final_idle_b", 1'b1, model(0, 8'h00, 1, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

Upstream companion of the serial byte receiver on the SCL/SDA link. Accepts a 4-bit PR value and a 3-bit Rate value over a valid/ready handshake. Packs them into one byte, `{1'b0, rate, pr}`, and shifts it out LSB-first on SCL/SDA. Framing matches the receiver: start = SDA low, one SCL-high cycle per bit, ack slot, stop.

## Interface
Parameters:
- LOW_CYCLES, default 2: SCL-low cycles per bit, also the start-hold length; legal range ≥1.
- GAP_CYCLES, default 4: SDA-high idle cycles after stop before the next frame; legal range ≥2.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- tx_valid  in  1  request to send.
- tx_ready  out  1  high only in IDLE; a transfer occurs on tx_valid && tx_ready.
- pr  in  4  PR payload, byte bits [3:0].
- rate  in  3  Rate payload, byte bits [6:4].
- scl  out  1  serial clock.
- sda_out  out  1  SDA drive value.
- sda_oe  out  1  SDA drive enable; 0 releases the line to the pull-up.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the STOP cycle.

## Operation
- States:
  - IDLE: scl=0, sda_out=1, sda_oe=1, tx_ready=1.
  - START: LOW_CYCLES cycles; scl=0, sda_out=0.
  - BIT_LOW: LOW_CYCLES cycles; scl=0, sda_out=shreg[0].
  - BIT_HIGH: exactly 1 cycle; scl=1, sda_out=shreg[0].
  - ACK: 1 cycle; scl=0, sda_oe=0.
  - STOP: 1 cycle; scl=0, sda_out=1, done=1.
  - GAP: GAP_CYCLES cycles; scl=0, sda_out=1.
- Transitions:
  - IDLE→START on handshake; the byte `{1'b0, rate, pr}` is latched into shreg at the same edge.
  - START→BIT_LOW; BIT_LOW→BIT_HIGH when the cycle counter expires.
  - BIT_HIGH→BIT_LOW if bit_cnt<7, else →ACK. shreg shifts right and bit_cnt increments on leaving BIT_HIGH.
  - ACK→STOP→GAP→IDLE.
- SCL high lasts exactly one clk per bit. The receiver samples on every high cycle, so a longer high phase would duplicate bits.
- SDA changes only while scl=0. sda_oe=1 everywhere except ACK.
- tx_valid is ignored while busy. Payload inputs are sampled only at the handshake edge.
- bit_cnt is 3 bits, 0..7, with no wrap past 7. The cycle counter width is $clog2(max(LOW_CYCLES, GAP_CYCLES))+1. It reloads on every state entry.
- Reset at any point, including mid-frame, forces IDLE at the next edge. The reset-state outputs are also the reset values of all outputs: scl=0, sda_out=1, sda_oe=1, tx_ready=1, busy=0, done=0. shreg, bit_cnt and the counter clear to 0. No partial frame resumes.
- Outputs are decoded from registered state only, with no input-to-output combinational path.

## Timing
- Handshake in cycle 0 puts START in cycles 1..LOW_CYCLES.
- Bit i is high at cycle LOW_CYCLES + 1 + i*(LOW_CYCLES+1) + LOW_CYCLES.
- ACK follows the bit-7 high cycle, then STOP, then GAP_CYCLES of GAP.
- Frame period = LOW_CYCLES + 8*(LOW_CYCLES+1) + 2 + GAP_CYCLES + 1. The final +1 is the IDLE handshake cycle.
- With defaults:
  - START in cycles 1–2; bit high cycles at 5, 8, …, 26.
  - ACK at 27, STOP/done at 28, GAP 29–32.
  - tx_ready=1 from cycle 33; back-to-back handshake at 33, next START at 34.
- GAP_CYCLES≥2 guarantees the receiver has returned to idle before the next start edge.

## Structure
- Package serial_link_pkg holds:
  - state enum;
  - FRAME_BITS=8, ACK_LEN=1, STOP_LEN=1;
  - byte field positions PR_LSB=0, RATE_LSB=4, SPARE_BIT=7.
- The receiver shares this package.
- One sub-module, serial_bit_timer: a loadable down-counter with a zero flag, used for the START, BIT_LOW and GAP durations.

## Test plan
- pr=4'hA, rate=3'd5, defaults: SDA bits at high cycles 5..26 read 0,1,0,1,1,0,1,0 (byte 0x5A). sda_oe=0 only at cycle 27, done at 28, tx_ready rises at 33.
- Loopback into the receiver: pr=4'h3, rate=3'd6 → receiver reports PR=3, Rate=6. Then send pr=4'hF, rate=3'd0 back-to-back → PR=F, Rate=0, with no false start during the gap.
- tx_valid held high continuously with changing pr: only values present at handshake cycles are sent; exactly one frame per 33 cycles.
- Reset asserted at cycle 12 mid-frame: at cycle 13, scl=0, sda_out=1, busy=0, tx_ready=1. A new frame then starts cleanly.
- LOW_CYCLES=1, GAP_CYCLES=2: bit high cycles at 3, 5, …, 17. Frame period 1+16+2+2+1=22 cycles.
- SCL never stays high for 2 consecutive cycles, and SDA never toggles while scl=1. Both are asserted across 100 random back-to-back frames.
